// File: rtl/signed_result_to_bcd.sv
// ----------------------------------------------------------------------------
// signed_result_to_bcd: signed two's-complement value -> sign + BCD, one bit/clk
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module signed_result_to_bcd #(
  parameter int WIDTH  = 5,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  busy
);

  localparam int            BW   = 4 * DIGITS;
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                sign_q, sign_d;
  logic [WIDTH-1:0]    mag_q, mag_d;
  logic [BW-1:0]       scr_q, scr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                out_sign_q, out_sign_d;
  logic [BW-1:0]       out_bcd_q, out_bcd_d;

  logic [WIDTH-1:0]    in_mag;
  logic [BW-1:0]       scr_adj;
  logic [BW+WIDTH-1:0] shifted;

  // Negating in WIDTH bits keeps the most-negative value exact as an unsigned magnitude
  assign in_mag = in_data[WIDTH-1] ? (~in_data + WIDTH'(1)) : in_data;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    assign scr_adj[4*g +: 4] = (scr_q[4*g +: 4] >= 4'd5) ? (scr_q[4*g +: 4] + 4'd3)
                                                          : scr_q[4*g +: 4];
  end

  assign shifted = {scr_adj, mag_q} << 1;

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    out_sign_d = out_sign_q;
    out_bcd_d  = out_bcd_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d  = in_data[WIDTH-1];
          mag_d   = in_mag;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        scr_d = shifted[BW+WIDTH-1:WIDTH];
        mag_d = shifted[WIDTH-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          out_sign_d = sign_q;
          out_bcd_d  = shifted[BW+WIDTH-1:WIDTH];
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      scr_q      <= '0;
      cnt_q      <= '0;
      out_sign_q <= 1'b0;
      out_bcd_q  <= '0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      out_sign_q <= out_sign_d;
      out_bcd_q  <= out_bcd_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_CONV);
  assign out_valid = (state_q == S_DONE);
  assign out_sign  = out_sign_q;
  assign out_bcd   = out_bcd_q;

endmodule

`default_nettype wire
